// File: rtl/mem2axi_repack_if.sv
// mem2axi_repack_if: AXI-Stream beat bundle (data, strobes, user, last)
// with valid/ready handshake; master drives the beat, slave drives ready.
interface mem2axi_repack_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 16
);
    logic [TDATA_WIDTH*8-1:0] m_tdata;
    logic [TDATA_WIDTH-1:0]   m_tstrb;
    logic [TUSER_WIDTH*8-1:0] m_tuser;
    logic                     m_tlast;
    logic                     m_tvalid;
    logic                     m_tready;

    modport master (
        output m_tdata, m_tstrb, m_tuser,
        output m_tlast, m_tvalid,
        input  m_tready
    );

    modport slave (
        input  m_tdata, m_tstrb, m_tuser,
        input  m_tlast, m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/mem2axi_repack.sv
// mem2axi_repack: repacks 24-byte memory words into 32-byte AXI beats.
// Define MEM2AXI_REPACK_PKT_CNT_EN to add the accepted-packet counter.
module mem2axi_repack #(
    parameter int TDATA_WIDTH        = 32,
    parameter int TUSER_WIDTH        = 16,
    parameter int CROPPED_DATA_WIDTH = 24
) (
    input  logic                            memclk,
    input  logic                            reset,
    input  logic [CROPPED_DATA_WIDTH*8-1:0] din,
    input  logic                            din_last,
    input  logic [4:0]                      din_bytes,
    input  logic                            din_valid,
    output logic                            din_rd,
    mem2axi_repack_if.master                m_axis,
    output logic [31:0]                     pkt_count
);
    localparam int DW = TDATA_WIDTH * 8;
    localparam int UW = TUSER_WIDTH * 8;
    localparam int CW = CROPPED_DATA_WIDTH * 8;
    localparam int SW = 2 * CW;
    localparam int HW = SW - DW;

    typedef enum logic [2:0] {
        HDR, R0, R24, R16, R8, FLUSH
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          res_q, res_d;
    logic [5:0]             fl_q, fl_d;
    logic [UW-1:0]          hdr_q, hdr_d;
    logic [DW-1:0]          tdata_q, tdata_d;
    logic [TDATA_WIDTH-1:0] tstrb_q, tstrb_d;
    logic [UW-1:0]          tuser_q, tuser_d;
    logic                   tlast_q, tlast_d;
    logic                   tvalid_q, tvalid_d;

    logic [CW-1:0] din_x;
    logic [SW-1:0] cat;
    logic [5:0]    r_bytes;
    logic [5:0]    n_bytes;
    logic          out_free;
    logic          beat_pop;
    logic          pop;

    function automatic logic [TDATA_WIDTH-1:0] lo_mask(
        input logic [5:0] c
    );
        logic [TDATA_WIDTH-1:0] m;
        for (int i = 0; i < TDATA_WIDTH; i++)
            m[i] = 6'(i) < c;
        return m;
    endfunction

    // Zero the bytes of a last word beyond din_bytes.
    always_comb begin
        din_x = din;
        if (din_last)
            for (int i = 0; i < CROPPED_DATA_WIDTH; i++)
                if (5'(i) >= din_bytes)
                    din_x[8*i +: 8] = '0;
    end

    // Place the incoming word directly above the held residue.
    always_comb begin
        r_bytes = 6'd0;
        cat     = {{CW{1'b0}}, din_x};
        unique case (state_q)
            R24: begin
                r_bytes = 6'd24;
                cat     = {din_x, res_q};
            end
            R16: begin
                r_bytes = 6'd16;
                cat     = {{(CW-128){1'b0}}, din_x, res_q[127:0]};
            end
            R8: begin
                r_bytes = 6'd8;
                cat     = {{(CW-64){1'b0}}, din_x, res_q[63:0]};
            end
            default: ;
        endcase
    end

    assign n_bytes = r_bytes + {1'b0, din_bytes};

    // Next-state, pop decision and output-register load.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        fl_d     = fl_q;
        hdr_d    = hdr_q;
        tdata_d  = tdata_q;
        tstrb_d  = tstrb_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q & ~m_axis.m_tready;
        out_free = ~tvalid_q | m_axis.m_tready;
        beat_pop = (state_q != HDR)
                && !(state_q == R0 && !din_last);
        pop      = din_valid && !reset
                && (state_q != FLUSH)
                && (!beat_pop || out_free);
        din_rd   = pop;

        if (state_q == FLUSH) begin
            if (out_free) begin
                tvalid_d = 1'b1;
                tdata_d  = {{(DW-CW){1'b0}}, res_q};
                tstrb_d  = lo_mask(fl_q);
                tuser_d  = hdr_q;
                tlast_d  = 1'b1;
                res_d    = '0;
                state_d  = HDR;
            end
        end else if (pop) begin
            if (state_q == HDR) begin
                // A lone last word is a header with no payload: drop it.
                if (!din_last) begin
                    hdr_d   = din[UW-1:0];
                    state_d = R0;
                end
            end else if (state_q == R0 && !din_last) begin
                res_d   = din;
                state_d = R24;
            end else begin
                tvalid_d = 1'b1;
                tdata_d  = cat[DW-1:0];
                tuser_d  = hdr_q;
                tstrb_d  = '1;
                tlast_d  = 1'b0;
                res_d    = {{(CW-HW){1'b0}}, cat[SW-1:DW]};
                if (din_last) begin
                    if (n_bytes <= 6'd32) begin
                        tstrb_d = lo_mask(n_bytes);
                        tlast_d = 1'b1;
                        res_d   = '0;
                        state_d = HDR;
                    end else begin
                        fl_d    = n_bytes - 6'd32;
                        state_d = FLUSH;
                    end
                end else begin
                    unique case (state_q)
                        R24:     state_d = R16;
                        R16:     state_d = R8;
                        default: state_d = R0;
                    endcase
                end
            end
        end
    end

    // State, residue, header and output register update.
    always_ff @(posedge memclk) begin
        if (reset) begin
            state_q  <= HDR;
            res_q    <= '0;
            fl_q     <= '0;
            hdr_q    <= '0;
            tdata_q  <= '0;
            tstrb_q  <= '0;
            tuser_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            fl_q     <= fl_d;
            hdr_q    <= hdr_d;
            tdata_q  <= tdata_d;
            tstrb_q  <= tstrb_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign m_axis.m_tdata  = tdata_q;
    assign m_axis.m_tstrb  = tstrb_q;
    assign m_axis.m_tuser  = tuser_q;
    assign m_axis.m_tlast  = tlast_q;
    assign m_axis.m_tvalid = tvalid_q;

`ifdef MEM2AXI_REPACK_PKT_CNT_EN
    logic [31:0] cnt_q;

    // Count packets whose last beat is accepted downstream.
    always_ff @(posedge memclk) begin
        if (reset)
            cnt_q <= '0;
        else if (tvalid_q && m_axis.m_tready && tlast_q)
            cnt_q <= cnt_q + 32'd1;
    end

    assign pkt_count = cnt_q;
`else
    assign pkt_count = '0;
`endif
endmodule

// File: tb/tb_mem2axi_repack.sv
// tb_mem2axi_repack: directed checks of header parse, repacking, flush,
// backpressure, mid-packet reset and packet counting.
`timescale 1ns/1ps
module tb_mem2axi_repack;
    logic         memclk    = 1'b0;
    logic         reset     = 1'b1;
    logic [191:0] din       = '0;
    logic         din_last  = 1'b0;
    logic [4:0]   din_bytes = '0;
    logic         din_valid = 1'b0;
    logic         din_rd;
    logic [31:0]  pkt_count;

    mem2axi_repack_if axis ();

    mem2axi_repack dut (
        .memclk    (memclk),
        .reset     (reset),
        .din       (din),
        .din_last  (din_last),
        .din_bytes (din_bytes),
        .din_valid (din_valid),
        .din_rd    (din_rd),
        .m_axis    (axis),
        .pkt_count (pkt_count)
    );

    always #5 memclk = ~memclk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [191:0] q_d[$];
    logic         q_l[$];
    logic [4:0]   q_b[$];

    logic [255:0] bt_d[$];
    logic [31:0]  bt_s[$];
    logic [127:0] bt_u[$];
    logic         bt_l[$];

    task automatic check(input string tag,
                         input logic [255:0] got,
                         input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [191:0] mkword(input logic [7:0] b);
        logic [191:0] w;
        for (int j = 0; j < 24; j++)
            w[8*j +: 8] = b + 8'(j);
        return w;
    endfunction

    function automatic logic [255:0] mkbeat(input logic [7:0] b,
                                            input int n);
        logic [255:0] w;
        w = '0;
        for (int j = 0; j < n; j++)
            w[8*j +: 8] = b + 8'(j);
        return w;
    endfunction

    task automatic push(input logic [191:0] w,
                        input logic l,
                        input logic [4:0] nb);
        q_d.push_back(w);
        q_l.push_back(l);
        q_b.push_back(nb);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge memclk);
            #2;
        end
    endtask

    task automatic clr_beats();
        bt_d.delete();
        bt_s.delete();
        bt_u.delete();
        bt_l.delete();
    endtask

    task automatic wait_beats(input int n);
        int c;
        c = 0;
        while (bt_d.size() < n && c < 300) begin
            cyc(1);
            c++;
        end
        cyc(4);
        check("beat_count", 256'(bt_d.size()), 256'(n));
    endtask

    task automatic chk_beat(input int k,
                            input logic [255:0] d,
                            input logic [31:0] s,
                            input logic [127:0] u,
                            input logic l);
        check($sformatf("b%0d.data", k), bt_d[k], d);
        check($sformatf("b%0d.strb", k), 256'(bt_s[k]), 256'(s));
        check($sformatf("b%0d.user", k), 256'(bt_u[k]), 256'(u));
        check($sformatf("b%0d.last", k), 256'(bt_l[k]), 256'(l));
    endtask

    // Source: pop the queue head on each accepted din_rd.
    initial begin : feeder
        logic p;
        forever begin
            @(negedge memclk);
            p = din_rd;
            @(posedge memclk);
            #1;
            if (p && q_d.size() > 0) begin
                void'(q_d.pop_front());
                void'(q_l.pop_front());
                void'(q_b.pop_front());
            end
            din_valid = q_d.size() > 0;
            if (q_d.size() > 0) begin
                din       = q_d[0];
                din_last  = q_l[0];
                din_bytes = q_b[0];
            end
        end
    end

    // Sink: record beats that will be accepted on the next edge.
    always @(negedge memclk) begin
        if (!reset && axis.m_tvalid && axis.m_tready) begin
            bt_d.push_back(axis.m_tdata);
            bt_s.push_back(axis.m_tstrb);
            bt_u.push_back(axis.m_tuser);
            bt_l.push_back(axis.m_tlast);
        end
    end

    logic [191:0] h1, h2, h3, h4, h5, h6, h7;
    logic [31:0]  exp_cnt;

    initial begin
        axis.m_tready = 1'b0;
        h1 = mkword(8'hAB);
        h2 = mkword(8'h50);
        h3 = mkword(8'h70);
        h4 = mkword(8'hA0);
        h5 = mkword(8'h10);
        h6 = mkword(8'h33);
        h7 = mkword(8'h44);

        cyc(2);
        push(h1, 1'b0, 5'd0);
        cyc(1);
        check("rst.din_rd", 256'(din_rd), 256'(0));
        check("rst.tvalid", 256'(axis.m_tvalid), 256'(0));
        check("rst.tlast", 256'(axis.m_tlast), 256'(0));
        check("rst.tdata", axis.m_tdata, 256'(0));
        check("rst.tstrb", 256'(axis.m_tstrb), 256'(0));
        check("rst.tuser", 256'(axis.m_tuser), 256'(0));
        check("rst.cnt", 256'(pkt_count), 256'(0));
        reset = 1'b0;
        axis.m_tready = 1'b1;

        // Four words, last full: three full beats.
        for (int k = 0; k < 4; k++)
            push(mkword(8'(24*k)), k == 3, 5'd24);
        wait_beats(3);
        for (int k = 0; k < 3; k++)
            chk_beat(k, mkbeat(8'(32*k), 32), 32'hFFFF_FFFF,
                     h1[127:0], k == 2);
        clr_beats();

        // Single short word.
        push(h2, 1'b0, 5'd0);
        push(mkword(8'hC0), 1'b1, 5'd5);
        wait_beats(1);
        chk_beat(0, 256'hC4C3C2C1C0, 32'h0000_001F,
                 h2[127:0], 1'b1);
        clr_beats();

        // Overflow into a flush beat (n = 44).
        push(h3, 1'b0, 5'd0);
        push(mkword(8'd0), 1'b0, 5'd0);
        push(mkword(8'd24), 1'b1, 5'd20);
        wait_beats(2);
        chk_beat(0, mkbeat(8'd0, 32), 32'hFFFF_FFFF,
                 h3[127:0], 1'b0);
        chk_beat(1, mkbeat(8'd32, 12), 32'h0000_0FFF,
                 h3[127:0], 1'b1);
        clr_beats();

        // Backpressure: six words, stalled for ten cycles.
        axis.m_tready = 1'b0;
        push(h4, 1'b0, 5'd0);
        for (int k = 0; k < 6; k++)
            push(mkword(8'(24*k)), k == 5, 5'd24);
        cyc(8);
        for (int k = 0; k < 10; k++) begin
            check("stall.din_rd", 256'(din_rd), 256'(0));
            check("stall.tvalid", 256'(axis.m_tvalid), 256'(1));
            check("stall.tdata", axis.m_tdata, mkbeat(8'd0, 32));
            cyc(1);
        end
        check("stall.nobeat", 256'(bt_d.size()), 256'(0));
        axis.m_tready = 1'b1;
        wait_beats(5);
        for (int k = 0; k < 4; k++)
            chk_beat(k, mkbeat(8'(32*k), 32), 32'hFFFF_FFFF,
                     h4[127:0], 1'b0);
        chk_beat(4, mkbeat(8'd128, 16), 32'h0000_FFFF,
                 h4[127:0], 1'b1);
        clr_beats();

`ifdef MEM2AXI_REPACK_PKT_CNT_EN
        exp_cnt = 32'd4;
`else
        exp_cnt = 32'd0;
`endif
        check("cnt.four", 256'(pkt_count), 256'(exp_cnt));

        // Reset while in R16 with a beat pending.
        axis.m_tready = 1'b0;
        push(h5, 1'b0, 5'd0);
        push(mkword(8'd0), 1'b0, 5'd0);
        push(mkword(8'd24), 1'b0, 5'd0);
        push(mkword(8'd48), 1'b0, 5'd0);
        cyc(10);
        check("pre_rst.tvalid", 256'(axis.m_tvalid), 256'(1));
        reset = 1'b1;
        q_d.delete();
        q_l.delete();
        q_b.delete();
        cyc(1);
        check("mid_rst.tvalid", 256'(axis.m_tvalid), 256'(0));
        check("mid_rst.cnt", 256'(pkt_count), 256'(0));
        reset = 1'b0;
        axis.m_tready = 1'b1;
        cyc(1);
        clr_beats();
        push(h6, 1'b0, 5'd0);
        push(mkword(8'h60), 1'b1, 5'd3);
        wait_beats(1);
        chk_beat(0, mkbeat(8'h60, 3), 32'h0000_0007,
                 h6[127:0], 1'b1);
        clr_beats();

        // Header-only word, then two more packets.
        push(mkword(8'hEE), 1'b1, 5'd24);
        push(h7, 1'b0, 5'd0);
        push(mkword(8'h80), 1'b1, 5'd24);
        push(h5, 1'b0, 5'd0);
        push(mkword(8'h90), 1'b1, 5'd1);
        wait_beats(2);
        chk_beat(0, mkbeat(8'h80, 24), 32'h00FF_FFFF,
                 h7[127:0], 1'b1);
        chk_beat(1, mkbeat(8'h90, 1), 32'h0000_0001,
                 h5[127:0], 1'b1);
`ifdef MEM2AXI_REPACK_PKT_CNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        check("cnt.three", 256'(pkt_count), 256'(exp_cnt));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
